// File: rtl/module_ctrl_display.sv
// module_ctrl_display: arbitrated binary-to-BCD controller for a 4-digit 7-segment display
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   req_a/dato_a, ack_a    requester A (operand entry): level request, value, capture pulse
//   req_b/dato_b, ack_b    requester B (arithmetic result): level request, value, capture pulse
//   millares..unidades     BCD digits of the last completed conversion
//   listo, ocupado         digits valid / conversion in progress
//   scan_tick              one-cycle pulse every REFRESH_DIV cycles for the digit multiplexer
// Optional: define BLANK_CEROS_EN to drive leading zero digits to 4'hF (blank).
module module_ctrl_display #(
  parameter int WIDTH = 14,
  parameter int REFRESH_DIV = 27000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] dato_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] dato_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas,
  output logic [3:0]       centenas,
  output logic [3:0]       millares,
  output logic             listo,
  output logic             ocupado,
  output logic             scan_tick
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic [WIDTH-1:0] bin_q, bin_d, sel, sat;
  logic [15:0] bcd_q, bcd_d, dig_q, dig_d, adj, blank;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rc_q;
  logic listo_q, listo_d, ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic gnt_a, gnt_b;
  // ptr_q = 1 means B wins a tie; after any grant it points at the loser
  assign gnt_a = req_a & (~req_b | ~ptr_q);
  assign gnt_b = req_b & (~req_a | ptr_q);
  assign sel = gnt_b ? dato_b : dato_a;
  assign sat = 32'(sel) > 32'd9999 ? WIDTH'(9999) : sel;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
`ifdef BLANK_CEROS_EN
  logic m0, c0, d0;
  assign m0 = bcd_q[15:12] == 4'd0;
  assign c0 = m0 & (bcd_q[11:8] == 4'd0);
  assign d0 = c0 & (bcd_q[7:4] == 4'd0);
  assign blank = {m0 ? 4'hF : bcd_q[15:12], c0 ? 4'hF : bcd_q[11:8], d0 ? 4'hF : bcd_q[7:4], bcd_q[3:0]};
`else
  assign blank = bcd_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      listo_q <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      listo_q <= listo_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      rc_q    <= rc_q == RW'(REFRESH_DIV - 1) ? '0 : rc_q + 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    listo_d = listo_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    case (state_q)
      IDLE: if (gnt_a | gnt_b) begin
        state_d = CONV;
        ptr_d   = gnt_a;
        ack_a_d = gnt_a;
        ack_b_d = gnt_b;
        bin_d   = sat;
        bcd_d   = '0;
        cnt_d   = '0;
      end
      CONV: begin
        bcd_d   = 16'({adj, bin_q[WIDTH-1]});
        bin_d   = bin_q << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? FIN : CONV;
      end
      FIN: begin
        dig_d   = blank;
        listo_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ocupado   = state_q != IDLE;
    ack_a     = ack_a_q;
    ack_b     = ack_b_q;
    listo     = listo_q;
    {millares, centenas, decenas, unidades} = dig_q;
    scan_tick = rc_q == RW'(REFRESH_DIV - 1);
  end
endmodule
